// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the video/sprite blocks.
//   oam_dma_state_t       : state encoding of the OAM DMA engine
//   DMA_REG_ADDR_DEFAULT  : CPU address whose write starts an OAM DMA
//   OAM_DATA_ADDR_DEFAULT : video OAM data port written by the DMA
// ---------------------------------------------------------------------------
package video_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } oam_dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
// Sprite OAM DMA engine. A CPU write to DMA_REG_ADDR latches a source page,
// halts the CPU and copies 256 bytes from {page, 00..FF} to OAM_DATA_ADDR,
// one read followed by one write per byte, one bus access per CPU cycle.
//
// Optional feature: define OAM_DMA_ODD_ALIGN_EN to insert one extra ALIGN
// cycle when the halt cycle falls on an odd CPU cycle (parity register = 1).
// Without it the CPU is always halted for 513 CPU cycles.
//
// Ports
//   I_clock    : system clock, rising edge
//   I_reset    : asynchronous reset, active low
//   I_cpu_ce   : one-clock pulse per CPU cycle; all state advances on it
//   I_cpu_addr : CPU address        I_cpu_wren : CPU write strobe
//   I_cpu_data : CPU write data
//   O_cpu_rdy  : 1 = CPU runs, 0 = CPU halted (bus owned by DMA)
//   O_bus_addr : DMA bus address    O_bus_rden / O_bus_wren : DMA strobes
//   O_bus_data : DMA write data     I_bus_data : read data, valid at the
//                                                CPU cycle ending a read
//   O_busy     : high whenever the engine is not idle
// ---------------------------------------------------------------------------
module oam_dma
   import video_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
   parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
)(
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_cpu_ce,
   input  logic [15:0] I_cpu_addr,
   input  logic        I_cpu_wren,
   input  logic [7:0]  I_cpu_data,
   output logic        O_cpu_rdy,
   output logic [15:0] O_bus_addr,
   output logic        O_bus_rden,
   output logic        O_bus_wren,
   output logic [7:0]  O_bus_data,
   input  logic [7:0]  I_bus_data,
   output logic        O_busy
);

   oam_dma_state_t state_reg;
   logic [7:0]     page_reg;
   logic [7:0]     index_reg;
   logic [7:0]     data_q_reg;
   logic           cpu_rdy_reg;
   logic           busy_reg;
   logic           bus_rden_reg;
   logic           bus_wren_reg;
   logic [15:0]    bus_addr_reg;

   logic [7:0]     index_inc;
   logic           align_take;
   logic           trigger;

   assign index_inc = index_reg + 8'd1;
   assign trigger   = I_cpu_wren && (I_cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ODD_ALIGN_EN
   // Tracks odd/even CPU cycles so the first read lands on a fixed phase.
   logic parity_reg;

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         parity_reg <= 1'b0;
      end else if (I_cpu_ce) begin
         parity_reg <= ~parity_reg;
      end
   end

   assign align_take = parity_reg;
`else
   assign align_take = 1'b0;
`endif

   // Outputs are registered: each transition loads the output values that
   // belong to the state being entered, so strobes only move on CPU cycles.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state_reg    <= ST_IDLE;
         page_reg     <= 8'd0;
         index_reg    <= 8'd0;
         data_q_reg   <= 8'd0;
         cpu_rdy_reg  <= 1'b1;
         busy_reg     <= 1'b0;
         bus_rden_reg <= 1'b0;
         bus_wren_reg <= 1'b0;
         bus_addr_reg <= 16'd0;
      end else if (I_cpu_ce) begin
         unique case (state_reg)
            ST_IDLE: begin
               if (trigger) begin
                  page_reg    <= I_cpu_data;
                  index_reg   <= 8'd0;
                  state_reg   <= ST_HALT;
                  cpu_rdy_reg <= 1'b0;
                  busy_reg    <= 1'b1;
               end
            end
            ST_HALT: begin
               if (align_take) begin
                  state_reg <= ST_ALIGN;
               end else begin
                  state_reg    <= ST_READ;
                  bus_addr_reg <= {page_reg, index_reg};
                  bus_rden_reg <= 1'b1;
               end
            end
            ST_ALIGN: begin
               state_reg    <= ST_READ;
               bus_addr_reg <= {page_reg, index_reg};
               bus_rden_reg <= 1'b1;
            end
            ST_READ: begin
               data_q_reg   <= I_bus_data;
               state_reg    <= ST_WRITE;
               bus_addr_reg <= OAM_DATA_ADDR;
               bus_rden_reg <= 1'b0;
               bus_wren_reg <= 1'b1;
            end
            ST_WRITE: begin
               index_reg    <= index_inc;
               bus_wren_reg <= 1'b0;
               if (index_reg == 8'hFF) begin
                  state_reg    <= ST_IDLE;
                  cpu_rdy_reg  <= 1'b1;
                  busy_reg     <= 1'b0;
                  bus_addr_reg <= 16'd0;
               end else begin
                  state_reg    <= ST_READ;
                  bus_addr_reg <= {page_reg, index_inc};
                  bus_rden_reg <= 1'b1;
               end
            end
            default: begin
               state_reg    <= ST_IDLE;
               cpu_rdy_reg  <= 1'b1;
               busy_reg     <= 1'b0;
               bus_rden_reg <= 1'b0;
               bus_wren_reg <= 1'b0;
               bus_addr_reg <= 16'd0;
            end
         endcase
      end
   end

   assign O_cpu_rdy  = cpu_rdy_reg;
   assign O_busy     = busy_reg;
   assign O_bus_rden = bus_rden_reg;
   assign O_bus_wren = bus_wren_reg;
   assign O_bus_addr = bus_addr_reg;
   assign O_bus_data = data_q_reg;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
// Scoreboard bench for oam_dma. Each trigger pushes the full expected bus
// sequence (256 reads from the page, 256 writes of the read bytes to the OAM
// port) and the expected halt length; a monitor pops and compares on every
// CPU cycle that ends a bus access. The memory model is a pure function of
// the address, so expected data is known when the trigger is issued.
// Build with +define+OAM_DMA_ODD_ALIGN_EN to expect the ALIGN cycle.
// ---------------------------------------------------------------------------
module tb_oam_dma;

   typedef struct packed {
      logic        is_wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } xact_t;

   logic        I_clock = 1'b0;
   logic        I_reset;
   logic        I_cpu_ce;
   logic [15:0] I_cpu_addr;
   logic        I_cpu_wren;
   logic [7:0]  I_cpu_data;
   logic        O_cpu_rdy;
   logic [15:0] O_bus_addr;
   logic        O_bus_rden;
   logic        O_bus_wren;
   logic [7:0]  O_bus_data;
   logic [7:0]  I_bus_data;
   logic        O_busy;

   int          n_total  = 0;
   int          n_passed = 0;

   xact_t       exp_q[$];
   int          halt_q[$];
   int          writes_seen = 0;
   logic [15:0] last_rd = 16'd0;
   int          run_len = 0;
   int          ce_edges = 0;
   int          ce_phase = 0;
   int          ce_div = 1;
   bit          ce_rand = 1'b0;
   logic [7:0]  salt = 8'd0;

   oam_dma dut (
      .I_clock    (I_clock),
      .I_reset    (I_reset),
      .I_cpu_ce   (I_cpu_ce),
      .I_cpu_addr (I_cpu_addr),
      .I_cpu_wren (I_cpu_wren),
      .I_cpu_data (I_cpu_data),
      .O_cpu_rdy  (O_cpu_rdy),
      .O_bus_addr (O_bus_addr),
      .O_bus_rden (O_bus_rden),
      .O_bus_wren (O_bus_wren),
      .O_bus_data (O_bus_data),
      .I_bus_data (I_bus_data),
      .O_busy     (O_busy)
   );

   always #5 I_clock = ~I_clock;

   // Memory contents: low address byte xor 5A, optionally mixed with the page.
   function automatic logic [7:0] mem_rd(input logic [15:0] a, input logic [7:0] s);
      return a[7:0] ^ 8'h5A ^ (s & a[15:8]);
   endfunction

   assign I_bus_data = mem_rd(O_bus_addr, salt);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
   endtask

   // CPU cycle enable: changes just after the rising edge.
   initial begin
      I_cpu_ce = 1'b0;
      forever begin
         @(posedge I_clock);
         #1;
         ce_phase++;
         if (ce_rand) I_cpu_ce = ($urandom_range(0, 2) != 0);
         else         I_cpu_ce = ((ce_phase % ce_div) == 0);
      end
   end

   // Count CPU-cycle edges since reset release (mirrors the parity definition).
   initial begin
      forever begin
         @(posedge I_clock or negedge I_reset);
         if (!I_reset)      ce_edges = 0;
         else if (I_cpu_ce) ce_edges++;
      end
   end

   // Monitor / scoreboard, sampled on the falling edge.
   initial begin
      logic [27:0] cur, prev_out;
      bit          prev_ce, have_prev;
      xact_t       e;
      have_prev = 1'b0;
      prev_ce   = 1'b0;
      prev_out  = '0;
      forever begin
         @(negedge I_clock);
         if (!I_reset) begin
            run_len   = 0;
            have_prev = 1'b0;
         end else begin
            cur = {O_cpu_rdy, O_busy, O_bus_rden, O_bus_wren, O_bus_addr, O_bus_data};
            if (have_prev && !prev_ce) chk("stable_without_ce", 32'(cur), 32'(prev_out));
            if (I_cpu_ce) begin
               chk("rdy_vs_busy", 32'(O_cpu_rdy), 32'(!O_busy));
               if (!O_cpu_rdy) begin
                  run_len++;
               end else if (run_len > 0) begin
                  if (halt_q.size() == 0) chk("unexpected_halt", 32'(run_len), 32'd0);
                  else chk("halt_length", 32'(run_len), 32'(halt_q.pop_front()));
                  run_len = 0;
               end
               if (O_bus_rden || O_bus_wren) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_strobe", {14'd0, O_bus_rden, O_bus_wren, O_bus_addr}, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("strobe_kind", 32'({O_bus_rden, O_bus_wren}), e.is_wr ? 32'd1 : 32'd2);
                     chk("bus_addr", 32'(O_bus_addr), 32'(e.addr));
                     if (e.is_wr) begin
                        chk("bus_data", 32'(O_bus_data), 32'(e.data));
                        writes_seen++;
                     end else begin
                        last_rd = O_bus_addr;
                     end
                  end
               end
            end
            prev_out  = cur;
            prev_ce   = I_cpu_ce;
            have_prev = 1'b1;
         end
      end
   end

   // Hold a CPU write until a CPU cycle consumes it; returns the edge count
   // including the accepting edge.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int k);
      bit taken;
      taken      = 1'b0;
      I_cpu_addr = a;
      I_cpu_data = d;
      I_cpu_wren = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(posedge I_clock);
         if (I_cpu_ce) begin
            taken = 1'b1;
            break;
         end
      end
      #2;
      k          = ce_edges;
      I_cpu_wren = 1'b0;
      I_cpu_addr = 16'd0;
      chk("cpu_write_taken", 32'(taken), 32'd1);
   endtask

   task automatic trigger(input logic [7:0] page);
      int k, halt;
      cpu_write(16'h4014, page, k);
`ifdef OAM_DMA_ODD_ALIGN_EN
      // Parity in the halt cycle equals the number of CPU cycles seen so far.
      halt = ((k % 2) == 1) ? 514 : 513;
`else
      halt = 513;
`endif
      halt_q.push_back(halt);
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back('{is_wr: 1'b0, addr: {page, 8'(i)}, data: 8'd0});
         exp_q.push_back('{is_wr: 1'b1, addr: 16'h2004, data: mem_rd({page, 8'(i)}, salt)});
      end
      writes_seen = 0;
      $display("xfer page=%h expected_halt=%0d", page, halt);
   endtask

   task automatic wait_done(input int budget);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < budget; t++) begin
         @(posedge I_clock);
         if (exp_q.size() == 0 && halt_q.size() == 0 && O_cpu_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("transfer_done", 32'(ok), 32'd1);
      repeat (10) @(posedge I_clock);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_cpu_rdy",  32'(O_cpu_rdy),  32'd1);
      chk("rst_busy",     32'(O_busy),     32'd0);
      chk("rst_bus_rden", 32'(O_bus_rden), 32'd0);
      chk("rst_bus_wren", 32'(O_bus_wren), 32'd0);
      chk("rst_bus_addr", 32'(O_bus_addr), 32'd0);
      chk("rst_bus_data", 32'(O_bus_data), 32'd0);
   endtask

   initial begin
      bit hit;
      int k;
      I_reset    = 1'b0;
      I_cpu_addr = 16'd0;
      I_cpu_wren = 1'b0;
      I_cpu_data = 8'd0;
      repeat (4) @(posedge I_clock);
      #1;
      check_reset_outputs();
      #2;
      I_reset = 1'b1;
      repeat (5) @(posedge I_clock);
      #1;

      // Page 02, CPU cycle every clock.
      ce_div = 1; ce_rand = 1'b0; salt = 8'h3C;
      trigger(8'h02);
      wait_done(3000);

      // Page 07 with plain addr^5A memory, CPU cycle every other clock.
      ce_div = 2; salt = 8'h00;
      trigger(8'h07);
      wait_done(5000);

      // Page 03, second trigger write at index 100 must be ignored.
      ce_rand = 1'b1; salt = 8'($urandom);
      trigger(8'h03);
      hit = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         @(posedge I_clock);
         if (writes_seen == 100) begin hit = 1'b1; break; end
      end
      chk("reach_index_100", 32'(hit), 32'd1);
      #1;
      cpu_write(16'h4014, 8'h09, k);
      wait_done(5000);

      // Reset mid-transfer at index 37 while in WRITE.
      ce_rand = 1'b0; ce_div = 1; salt = 8'($urandom);
      trigger(8'($urandom_range(0, 255)));
      hit = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         @(negedge I_clock);
         #1;
         if (writes_seen == 37 && O_bus_wren) begin hit = 1'b1; break; end
      end
      chk("reach_index_37_write", 32'(hit), 32'd1);
      I_reset = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      halt_q.delete();
      repeat (3) @(posedge I_clock);
      #2;
      I_reset = 1'b1;
      repeat (40) @(posedge I_clock);
      #1;
      trigger(8'($urandom_range(0, 255)));
      wait_done(3000);

      // Page FF with a CPU cycle every third clock: must end at FFFF.
      ce_div = 3;
      trigger(8'hFF);
      wait_done(8000);
      chk("last_read_addr", 32'(last_rd), 32'h0000FFFF);

      // A few random pages with random CPU-cycle spacing.
      ce_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         salt = 8'($urandom);
         trigger(8'($urandom_range(0, 255)));
         wait_done(5000);
      end

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL have parameter DMA_REG_ADDR, default 16'h4014, CPU address that triggers a transfer.
REQ-002 The block SHALL have parameter OAM_DATA_ADDR, default 16'h2004, video OAM data register address written by each transfer.
REQ-003 I_clock  input  1  system clock; all state SHALL be updated on the rising edge.
REQ-004 I_reset  input  1  reset, asynchronous, active-low.
REQ-005 I_cpu_ce  input  1  CPU cycle enable, one I_clock-wide pulse per CPU cycle.
REQ-006 I_cpu_addr  input  16  CPU address.
REQ-007 I_cpu_wren  input  1  CPU write strobe.
REQ-008 I_cpu_data  input  8  CPU write data.
REQ-009 O_cpu_rdy  output  1  high = CPU may run; low = CPU halted, bus owned by DMA.
REQ-010 O_bus_addr  output  16  DMA bus address.
REQ-011 O_bus_rden  output  1  DMA read strobe.
REQ-012 O_bus_wren  output  1  DMA write strobe.
REQ-013 O_bus_data  output  8  DMA write data.
REQ-014 I_bus_data  input  8  bus read data, valid in the I_cpu_ce cycle that ends a read.
REQ-015 O_busy  output  1  high in every state except IDLE.

Function
REQ-016 All state transitions and register updates SHALL occur only on I_clock edges where I_cpu_ce=1.
REQ-017 States SHALL be IDLE, HALT, ALIGN, READ and WRITE.
REQ-018 In IDLE, I_cpu_wren=1 with I_cpu_addr==DMA_REG_ADDR SHALL latch I_cpu_data into page[7:0], clear index[7:0] to 0 and transition to HALT.
REQ-019 Writes to DMA_REG_ADDR outside IDLE SHALL be ignored: no restart and no page change.
REQ-020 HALT SHALL last exactly one CPU cycle, then go to ALIGN if the ALIGN condition (REQ-033) holds, otherwise to READ.
REQ-021 ALIGN SHALL last exactly one CPU cycle, then go to READ.
REQ-022 In READ, O_bus_addr SHALL be {page, index} and O_bus_rden=1; at the ending I_cpu_ce, I_bus_data SHALL be latched into data_q, then go to WRITE.
REQ-023 In WRITE, O_bus_addr SHALL be OAM_DATA_ADDR, O_bus_wren=1 and O_bus_data=data_q; at the ending I_cpu_ce, index SHALL increment by 1 modulo 256.
REQ-024 WRITE with index==255 SHALL go to IDLE, otherwise to READ; exactly 256 read/write pairs SHALL occur per transfer.
REQ-025 O_cpu_rdy SHALL be 0 in HALT, ALIGN, READ and WRITE, and 1 in IDLE.
REQ-026 Outside READ, O_bus_rden SHALL be 0; outside WRITE, O_bus_wren SHALL be 0; in IDLE, O_bus_addr SHALL be 0.
REQ-027 A 1-bit parity register SHALL toggle on every I_cpu_ce, regardless of state.
REQ-028 Page 8'hFF SHALL read 16'hFF00..16'hFFFF with no special casing.

Reset
REQ-029 Asserting I_reset SHALL immediately force state=IDLE, page=0, index=0, data_q=0 and parity=0.
REQ-030 During reset, outputs SHALL be O_cpu_rdy=1, O_busy=0, O_bus_rden=0, O_bus_wren=0, O_bus_addr=0 and O_bus_data=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer; no further bus strobes SHALL occur until the next trigger.

Configuration
REQ-032 Macro OAM_DMA_ODD_ALIGN_EN SHALL control the ALIGN state.
REQ-033 With OAM_DMA_ODD_ALIGN_EN defined, ALIGN SHALL be entered when parity==1 in the HALT cycle, giving a 514-cycle halt; otherwise a 513-cycle halt.
REQ-034 Without OAM_DMA_ODD_ALIGN_EN, ALIGN SHALL never be entered, every transfer SHALL halt the CPU for 513 cycles, and the parity register may be omitted.

Structure
REQ-035 Package video_pkg SHALL hold the state enum type oam_dma_state_t and constants for DMA_REG_ADDR and OAM_DATA_ADDR defaults.
REQ-036 The block SHALL be a single module with no sub-modules; address generation and the state machine are too small to split.

Verification
REQ-037 Write 8'h02 to 16'h4014 on an even cycle, macro off -> reads 16'h0200..16'h02FF, 256 writes to 16'h2004 in order, O_cpu_rdy low for exactly 513 CPU cycles.
REQ-038 Macro on: trigger on an odd cycle -> O_cpu_rdy low for 514 cycles; trigger on an even cycle -> low for 513 cycles.
REQ-039 Memory preloaded with value = addr[7:0]^8'h5A, page 8'h07 -> OAM write sequence matches 8'h5A, 8'h5B, ... for all 256 bytes.
REQ-040 Second write to 16'h4014 (data 8'h09) at index 100 -> ignored; transfer completes from page 8'h03 with 256 writes total.
REQ-041 Reset asserted at index 37 in WRITE -> outputs reach reset values at once; no strobes afterward; a new trigger runs a full 256-byte transfer.
REQ-042 Page 8'hFF with I_cpu_ce asserted every 3rd clock -> last read address 16'hFFFF, no wrap into 16'h0000, strobes change only on I_cpu_ce edges.
